nios2_qsys_div_cell: RTL and testbench

Iterative 32-bit integer divider, the inverse companion of the processor's pipelined multiply cell. It accepts a dividend/divisor pair on a single-cycle start strobe and runs a radix-2 restoring division, one quotient bit per clock. It returns quotient and remainder with a one-cycle done pulse. It sits beside the multiply cell in the A-stage execute path and serves `div`/`divu`; the core stalls on `A_div_busy`.

---
 rtl/nios2_div_pkg.sv | 22 ++
 rtl/nios2_qsys_div_step.sv | 24 ++
 rtl/nios2_qsys_div_cell.sv | 141 ++++++++++++++
 tb/tb_nios2_qsys_div_cell.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_div_pkg.sv
// Shared types and helpers for the iterative divide cell.
package nios2_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        ITER,
        FIX
    } div_state_t;

    // Default operand width of the cell.
    localparam int DIV_DATA_W = 32;

    // Fill bit of the quotient returned for a zero divisor (all ones).
    localparam logic DIV_ZERO_FILL = 1'b1;

    // Width of the iteration counter, which counts DATA_W-1 down to 0.
    function automatic int div_cnt_w(input int data_w);
        return $clog2(data_w);
    endfunction

endpackage

// File: rtl/nios2_qsys_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference when it does not borrow.
module nios2_qsys_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   part_rem,
    input  logic [DATA_W-1:0] divisor,
    input  logic              next_bit,
    output logic [DATA_W:0]   new_rem,
    output logic              quot_bit
);

    // The partial remainder is always below the divisor, so its top bit is
    // zero and the extra bit of the trial difference is a clean borrow flag.
    logic [DATA_W+1:0] trial;

    // Shift, trial subtract, restore on borrow.
    always_comb begin
        trial    = {part_rem, next_bit} - {2'b00, divisor};
        quot_bit = ~trial[DATA_W+1];
        new_rem  = quot_bit ? trial[DATA_W:0] : {part_rem[DATA_W-1:0], next_bit};
    end

endmodule

// File: rtl/nios2_qsys_div_cell.sv
// Iterative 32-bit signed/unsigned divider: one quotient bit per clock,
// fixed latency, registered quotient/remainder with a one-cycle done pulse.
module nios2_qsys_div_cell
    import nios2_div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              A_div_start,
    input  logic              A_div_signed,
    input  logic [DATA_W-1:0] A_div_src1,
    input  logic [DATA_W-1:0] A_div_src2,
    output logic              A_div_busy,
    output logic              A_div_done,
    output logic [DATA_W-1:0] A_div_quot,
    output logic [DATA_W-1:0] A_div_rem
);

    localparam int CNT_W = div_cnt_w(DATA_W);

    div_state_t        state;
    div_state_t        next_state;
    logic [CNT_W-1:0]  cnt;

    // Raw operands captured with start; src1_q is also the divide-by-zero remainder.
    logic              sgn_mode;
    logic [DATA_W-1:0] src1_q;
    logic [DATA_W-1:0] src2_q;

    // Working registers: {rem_q, quot_sh} shift left as one long register.
    logic [DATA_W-1:0] dvs_mag;
    logic [DATA_W-1:0] quot_sh;
    logic [DATA_W:0]   rem_q;
    logic              quot_neg;
    logic              rem_neg;
    logic              div_zero;

    logic              src1_neg;
    logic              src2_neg;
    logic [DATA_W:0]   step_rem;
    logic              step_bit;

    assign src1_neg = sgn_mode & src1_q[DATA_W-1];
    assign src2_neg = sgn_mode & src2_q[DATA_W-1];

    nios2_qsys_div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .part_rem (rem_q),
        .divisor  (dvs_mag),
        .next_bit (quot_sh[DATA_W-1]),
        .new_rem  (step_rem),
        .quot_bit (step_bit)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic; start is only honoured in IDLE.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (A_div_start) next_state = PREP;
            PREP:    next_state = ITER;
            ITER:    if (cnt == '0) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, magnitude preparation and the shift/subtract iteration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            sgn_mode <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
            dvs_mag  <= '0;
            quot_sh  <= '0;
            rem_q    <= '0;
            quot_neg <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (A_div_start) begin
                        src1_q   <= A_div_src1;
                        src2_q   <= A_div_src2;
                        sgn_mode <= A_div_signed;
                    end
                end
                PREP: begin
                    quot_sh  <= src1_neg ? -src1_q : src1_q;
                    dvs_mag  <= src2_neg ? -src2_q : src2_q;
                    rem_q    <= '0;
                    quot_neg <= src1_neg ^ src2_neg;
                    rem_neg  <= src1_neg;
                    div_zero <= (src2_q == '0);
                    cnt      <= CNT_W'(DATA_W - 1);
                end
                ITER: begin
                    rem_q   <= step_rem;
                    quot_sh <= {quot_sh[DATA_W-2:0], step_bit};
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Registered outputs: busy tracks the next state, results load in FIX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            A_div_busy <= 1'b0;
            A_div_done <= 1'b0;
            A_div_quot <= '0;
            A_div_rem  <= '0;
        end else begin
            A_div_busy <= (next_state != IDLE);
            A_div_done <= (state == FIX);
            if (state == FIX) begin
                if (div_zero) begin
                    A_div_quot <= {DATA_W{DIV_ZERO_FILL}};
                    A_div_rem  <= src1_q;
                end else begin
                    A_div_quot <= quot_neg ? -quot_sh : quot_sh;
                    A_div_rem  <= rem_neg ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_nios2_qsys_div_cell.sv
// Self-checking bench for nios2_qsys_div_cell: directed corner cases plus
// randomized operands against an arithmetic reference model.
module tb_nios2_qsys_div_cell;

    localparam int DW       = 32;
    localparam int DONE_CYC = DW + 3;

    logic          clk;
    logic          reset;
    logic          start;
    logic          sgn;
    logic [DW-1:0] src1;
    logic [DW-1:0] src2;
    logic          busy;
    logic          done;
    logic [DW-1:0] quot;
    logic [DW-1:0] rem;

    int n_checks;
    int n_errors;

    logic [DW-1:0] prev_q;
    logic [DW-1:0] prev_r;

    nios2_qsys_div_cell #(
        .DATA_W (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .A_div_start  (start),
        .A_div_signed (sgn),
        .A_div_src1   (src1),
        .A_div_src2   (src2),
        .A_div_busy   (busy),
        .A_div_done   (done),
        .A_div_quot   (quot),
        .A_div_rem    (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division with 64-bit signed arithmetic.
    function automatic void ref_div(input logic sg, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    output logic [DW-1:0] q, output logic [DW-1:0] r);
        longint sa;
        longint sb;
        sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
        if (b == '0) begin
            q = '1;
            r = a;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    // Drive a start in the current cycle (caller is already #1 past the edge).
    task automatic drive(input logic sg, input logic [DW-1:0] a, input logic [DW-1:0] b);
        start = 1'b1;
        sgn   = sg;
        src1  = a;
        src2  = b;
    endtask

    task automatic launch(input logic sg, input logic [DW-1:0] a, input logic [DW-1:0] b);
        @(posedge clk);
        #1;
        drive(sg, a, b);
    endtask

    // Follow one operation from cycle 1 to the done cycle. Optionally pulse a
    // stray start at cycle glitch (0 = none). Ends #1 after the done edge.
    task automatic track(input string tag, input logic [DW-1:0] eq, input logic [DW-1:0] er,
                         input int glitch);
        int busy_err;
        int done_err;
        int hold_err;
        busy_err = 0;
        done_err = 0;
        hold_err = 0;
        for (int k = 1; k <= DONE_CYC; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                start = 1'b0;
                src1  = $urandom;
                src2  = $urandom;
                sgn   = 1'($urandom);
            end
            if (glitch != 0 && k == glitch) begin
                start = 1'b1;
                src1  = 32'd9;
                src2  = 32'd3;
            end
            if (glitch != 0 && k == glitch + 1) start = 1'b0;
            if (busy !== (k < DONE_CYC)) busy_err++;
            if (done !== (k == DONE_CYC)) done_err++;
            if (k < DONE_CYC && (quot !== prev_q || rem !== prev_r)) hold_err++;
        end
        check({tag, " busy"}, 32'(busy_err), 32'd0);
        check({tag, " done"}, 32'(done_err), 32'd0);
        check({tag, " hold"}, 32'(hold_err), 32'd0);
        check({tag, " quot"}, quot, eq);
        check({tag, " rem"},  rem,  er);
        prev_q = eq;
        prev_r = er;
    endtask

    typedef struct {
        logic          sg;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] q;
        logic [DW-1:0] r;
    } vec_t;

    vec_t dir[7];

    initial begin
        int done_seen;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] eq;
        logic [DW-1:0] er;
        logic          sg;

        n_checks = 0;
        n_errors = 0;
        prev_q   = '0;
        prev_r   = '0;
        reset    = 1'b1;
        start    = 1'b0;
        sgn      = 1'b0;
        src1     = '0;
        src2     = '0;

        dir[0] = '{1'b0, 32'd100,        32'd7,        32'd14,       32'd2};
        dir[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF};
        dir[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
        dir[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        dir[4] = '{1'b0, 32'hFFFF_FFFF,  32'h10,       32'h0FFF_FFFF, 32'hF};
        dir[5] = '{1'b0, 32'd1234,       32'd0,        32'hFFFF_FFFF, 32'h0000_04D2};
        dir[6] = '{1'b1, 32'hFFFF_FFFB,  32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFB};

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset quot", quot, 32'd0);
        check("reset rem",  rem,  32'd0);
        reset = 1'b0;

        // Directed vectors, chained back to back with start in each done cycle.
        // The first one also carries a stray start at cycle 10.
        launch(dir[0].sg, dir[0].a, dir[0].b);
        track("dir0", dir[0].q, dir[0].r, 10);
        for (int i = 1; i < 7; i++) begin
            drive(dir[i].sg, dir[i].a, dir[i].b);
            track($sformatf("dir%0d", i), dir[i].q, dir[i].r, 0);
        end

        // Reset in cycle 12 of an operation aborts it with no done pulse.
        launch(1'b0, 32'd500, 32'd3);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) start = 1'b0;
        end
        reset = 1'b1;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort quot", quot, 32'd0);
        check("abort rem",  rem,  32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check("abort no done", 32'(done_seen), 32'd0);
        prev_q = '0;
        prev_r = '0;
        launch(1'b0, 32'd100, 32'd7);
        track("post reset", 32'd14, 32'd2, 0);

        // Randomized operands, mixing gaps and back-to-back issue.
        for (int i = 0; i < 30; i++) begin
            sg = 1'($urandom);
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 4))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = '1;
                3:       b = 32'($urandom) >> $urandom_range(0, 31);
                default: b = 32'($urandom);
            endcase
            ref_div(sg, a, b, eq, er);
            if ($urandom_range(0, 1) == 0) launch(sg, a, b);
            else                           drive(sg, a, b);
            track($sformatf("rnd%0d", i), eq, er, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
